// File: rtl/bus_addr_dec_tmo_pkg.sv
// Shared definitions for the registered bus chip-select decoder:
// FSM state encodings, error cause codes and select polarity.
package bus_addr_dec_tmo_pkg;

    typedef enum logic [1:0] {
        BUS_DEC_IDLE   = 2'd0,
        BUS_DEC_ACCESS = 2'd1,
        BUS_DEC_ERROR  = 2'd2
    } bus_dec_state_e;

    typedef enum logic [1:0] {
        BUS_ERR_NONE     = 2'b00,
        BUS_ERR_UNMAPPED = 2'b01,
        BUS_ERR_TIMEOUT  = 2'b10
    } bus_err_e;

    localparam int BUS_SLAVE_IDX_WIDTH = 3;

    // Bus strobes, selects and readies are all active low.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    function automatic logic slave_mapped(input int idx, input int num_slaves);
        return idx < num_slaves;
    endfunction

endpackage

// File: rtl/bus_addr_dec_tmo_tmo_cnt.sv
// Loadable, clearable timeout counter that saturates at all ones and
// flags the terminal count TERMINAL-1 (never flags when TERMINAL is 0).
module bus_tmo_cnt #(
    parameter int WIDTH    = 8,
    parameter int TERMINAL = 255
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_tc
);

    localparam int               TC_INT = (TERMINAL > 0) ? TERMINAL - 1 : 0;
    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TC_INT);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (TERMINAL != 0) && (r_cnt == TC_VAL);

endmodule

// File: rtl/bus_addr_dec_tmo.sv
// Registered chip-select decoder: holds one active-low select until the
// addressed slave answers, and flags unmapped or timed-out accesses.
module bus_addr_dec_tmo
    import bus_addr_dec_tmo_pkg::*;
#(
    parameter int ADDR_WIDTH      = 30,
    parameter int SLAVE_IDX_WIDTH = BUS_SLAVE_IDX_WIDTH,
    parameter int NUM_SLAVES      = 8,
    parameter int TIMEOUT         = 255,
    parameter int TMO_CNT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  as_,
    input  logic [NUM_SLAVES-1:0] slave_rdy_,
    output logic [NUM_SLAVES-1:0] cs_,
    output logic                  err_rdy_,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  busy
);

    bus_dec_state_e              r_state;
    bus_dec_state_e              w_state_next;
    logic [SLAVE_IDX_WIDTH-1:0]  r_idx;
    logic [ADDR_WIDTH-1:0]       r_addr;
    logic [NUM_SLAVES-1:0]       r_cs_n;
    logic                        r_err;
    logic                        r_err_rdy_n;
    logic [1:0]                  r_err_code;
    logic [ADDR_WIDTH-1:0]       r_err_addr;
    logic                        r_busy;

    logic [SLAVE_IDX_WIDTH-1:0]  w_idx;
    logic                        w_mapped;
    logic [NUM_SLAVES-1:0]       w_new_sel;
    logic [NUM_SLAVES-1:0]       w_cur_sel;
    logic                        w_sel_rdy;
    logic                        w_tc;
    logic                        w_cnt_en;
    logic                        w_accept;
    logic                        w_err_fire;
    bus_err_e                    w_err_cause;
    logic [ADDR_WIDTH-1:0]       w_err_addr;
    logic [NUM_SLAVES-1:0]       w_cs_next;

    assign w_idx    = in_addr[ADDR_WIDTH-1 -: SLAVE_IDX_WIDTH];
    assign w_mapped = slave_mapped(int'(w_idx), NUM_SLAVES);

    // One-hot decode of the incoming index and of the latched index.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
            assign w_new_sel[gi] = (w_idx == SLAVE_IDX_WIDTH'(gi));
            assign w_cur_sel[gi] = (r_idx == SLAVE_IDX_WIDTH'(gi));
        end
    endgenerate

    // Only the selected slave's ready counts; others are masked off.
    assign w_sel_rdy = |(w_cur_sel & ~slave_rdy_);
    assign w_cnt_en  = (r_state == BUS_DEC_ACCESS) && (TIMEOUT != 0);

    bus_tmo_cnt #(
        .WIDTH    (TMO_CNT_WIDTH),
        .TERMINAL (TIMEOUT)
    ) u_tmo_cnt (
        .clk        (clk),
        .reset_     (reset_),
        .i_clr      (w_accept),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_cnt_en),
        .o_tc       (w_tc)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_err_fire   = 1'b0;
        w_err_cause  = BUS_ERR_NONE;
        w_err_addr   = r_addr;
        w_cs_next    = {NUM_SLAVES{DISABLE_}};
        unique case (r_state)
            BUS_DEC_IDLE: begin
                if (as_ == ENABLE_) begin
                    if (w_mapped) begin
                        w_state_next = BUS_DEC_ACCESS;
                        w_accept     = 1'b1;
                        w_cs_next    = ~w_new_sel;
                    end else begin
                        w_state_next = BUS_DEC_ERROR;
                        w_err_fire   = 1'b1;
                        w_err_cause  = BUS_ERR_UNMAPPED;
                        w_err_addr   = in_addr;
                    end
                end
            end
            BUS_DEC_ACCESS: begin
                // Ready beats both abort and timeout in the same cycle.
                if (w_sel_rdy || (as_ == DISABLE_)) begin
                    w_state_next = BUS_DEC_IDLE;
                end else if (w_tc) begin
                    w_state_next = BUS_DEC_ERROR;
                    w_err_fire   = 1'b1;
                    w_err_cause  = BUS_ERR_TIMEOUT;
                end else begin
                    w_cs_next    = ~w_cur_sel;
                end
            end
            BUS_DEC_ERROR: begin
                w_state_next = BUS_DEC_IDLE;
            end
            default: begin
                w_state_next = BUS_DEC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state     <= BUS_DEC_IDLE;
            r_idx       <= '0;
            r_addr      <= '0;
            r_cs_n      <= {NUM_SLAVES{DISABLE_}};
            r_err       <= 1'b0;
            r_err_rdy_n <= DISABLE_;
            r_err_code  <= BUS_ERR_NONE;
            r_err_addr  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cs_n      <= w_cs_next;
            r_err       <= w_err_fire;
            r_err_rdy_n <= w_err_fire ? ENABLE_ : DISABLE_;
            r_busy      <= (w_state_next != BUS_DEC_IDLE);
            if (w_accept) begin
                r_idx  <= w_idx;
                r_addr <= in_addr;
            end
            if (w_err_fire) begin
                r_err_code <= w_err_cause;
                r_err_addr <= w_err_addr;
            end
        end
    end

    assign cs_      = r_cs_n;
    assign err      = r_err;
    assign err_rdy_ = r_err_rdy_n;
    assign err_code = r_err_code;
    assign err_addr = r_err_addr;
    assign busy     = r_busy;

endmodule

// File: tb/tb_bus_addr_dec_tmo.sv
// Scoreboard bench for bus_addr_dec_tmo: each access pushes its expected
// select/error profile, which is checked when busy drops.
module tb_bus_addr_dec_tmo;

    localparam int AW  = 30;
    localparam int SIW = 3;
    localparam int NS  = 5;
    localparam int TMO = 4;
    localparam int TCW = 8;

    logic          clk = 1'b0;
    logic          reset_;
    logic [AW-1:0] in_addr;
    logic          as_;
    logic [NS-1:0] slave_rdy_;
    logic [NS-1:0] cs_;
    logic          err_rdy_;
    logic          err;
    logic [1:0]    err_code;
    logic [AW-1:0] err_addr;
    logic          busy;

    always #5 clk = ~clk;

    bus_addr_dec_tmo #(
        .ADDR_WIDTH      (AW),
        .SLAVE_IDX_WIDTH (SIW),
        .NUM_SLAVES      (NS),
        .TIMEOUT         (TMO),
        .TMO_CNT_WIDTH   (TCW)
    ) dut (
        .clk        (clk),
        .reset_     (reset_),
        .in_addr    (in_addr),
        .as_        (as_),
        .slave_rdy_ (slave_rdy_),
        .cs_        (cs_),
        .err_rdy_   (err_rdy_),
        .err        (err),
        .err_code   (err_code),
        .err_addr   (err_addr),
        .busy       (busy)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int            cs_cyc;
        logic [NS-1:0] cs_and;
        int            err_cyc;
        int            erdy_cyc;
        logic [1:0]    code;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t          sb_q[$];
    logic [1:0]    last_code = 2'b00;
    logic [AW-1:0] last_addr = '0;

    // Monitor: accumulate per-access observations, compare when busy falls.
    initial begin
        int            m_cs;
        int            m_err;
        int            m_erdy;
        int            m_tid;
        logic [NS-1:0] m_and;
        logic          m_prev_busy;
        exp_t          e;
        m_cs = 0; m_err = 0; m_erdy = 0; m_tid = 0; m_and = '1; m_prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_) begin
                m_cs = 0; m_err = 0; m_erdy = 0; m_and = '1; m_prev_busy = 1'b0;
            end else begin
                if (cs_ != '1) begin
                    m_cs++;
                    m_and &= cs_;
                end
                if (err)       m_err++;
                if (!err_rdy_) m_erdy++;
                if (m_prev_busy && !busy) begin
                    if (sb_q.size() == 0) begin
                        check_val($sformatf("t%0d sb_empty", m_tid), 64'(sb_q.size()), 64'd1);
                    end else begin
                        e = sb_q.pop_front();
                        check_val($sformatf("t%0d cs_cycles", m_tid), 64'(m_cs), 64'(e.cs_cyc));
                        check_val($sformatf("t%0d cs_pattern", m_tid), 64'(m_and), 64'(e.cs_and));
                        check_val($sformatf("t%0d err_cycles", m_tid), 64'(m_err), 64'(e.err_cyc));
                        check_val($sformatf("t%0d err_rdy_cycles", m_tid), 64'(m_erdy), 64'(e.erdy_cyc));
                        check_val($sformatf("t%0d err_code", m_tid), 64'(err_code), 64'(e.code));
                        check_val($sformatf("t%0d err_addr", m_tid), 64'(err_addr), 64'(e.addr));
                    end
                    $display("txn %0d: cs_cycles=%0d cs=%b err_cycles=%0d err_code=%b err_addr=%h",
                             m_tid, m_cs, m_and, m_err, err_code, err_addr);
                    m_tid++;
                    m_cs = 0; m_err = 0; m_erdy = 0; m_and = '1;
                end
                m_prev_busy = busy;
            end
        end
    end

    // mode 0: ready on slave rs at cycle k; 1: abort from cycle k;
    // 2: no response; 3: abort and ready on slave rs together at cycle k.
    // Called at a negedge; returns at the negedge where busy has dropped.
    task automatic run_txn(input logic [SIW-1:0] idx, input logic [AW-SIW-1:0] low,
                           input int mode, input int k, input int rs);
        exp_t          e;
        logic [AW-1:0] a;
        logic [NS-1:0] sel_n;
        logic [NS-1:0] exp_cs;
        logic          mapped;
        logic          completes;
        int            j;
        a         = {idx, low};
        mapped    = int'(idx) < NS;
        sel_n     = ~(NS'(1) << idx);
        completes = (k <= TMO) && ((mode == 1) || (mode == 3) || (mode == 0 && rs == int'(idx)));
        e.cs_and  = '1;
        e.cs_cyc  = 0;
        e.err_cyc = 0;
        e.erdy_cyc = 0;
        if (!mapped) begin
            e.err_cyc = 1; e.erdy_cyc = 1;
            last_code = 2'b01; last_addr = a;
        end else if (completes) begin
            e.cs_cyc = k; e.cs_and = sel_n;
        end else begin
            e.cs_cyc = TMO; e.cs_and = sel_n; e.err_cyc = 1; e.erdy_cyc = 1;
            last_code = 2'b10; last_addr = a;
        end
        e.code = last_code;
        e.addr = last_addr;
        sb_q.push_back(e);

        in_addr    = a;
        as_        = 1'b0;
        slave_rdy_ = '1;
        @(posedge clk); #1;
        exp_cs = mapped ? sel_n : '1;
        check_val($sformatf("cs_latency idx%0d", idx), 64'(cs_), 64'(exp_cs));
        j = 1;
        forever begin
            @(negedge clk);
            if (!busy) break;
            if (j > 40) begin
                check_val("busy_stuck", 64'(busy), 64'd0);
                break;
            end
            slave_rdy_ = '1;
            if ((mode == 0 || mode == 3) && j == k) slave_rdy_[rs] = 1'b0;
            if ((mode == 1 && j >= k) || (mode == 3 && j == k)) as_ = 1'b1;
            j++;
        end
        as_        = 1'b1;
        slave_rdy_ = '1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_     = 1'b0;
        as_        = 1'b1;
        in_addr    = '0;
        slave_rdy_ = '1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst cs_", 64'(cs_), 64'h1f);
        check_val("rst busy", 64'(busy), 64'd0);
        check_val("rst err", 64'(err), 64'd0);
        check_val("rst err_rdy_", 64'(err_rdy_), 64'd1);
        check_val("rst err_code", 64'(err_code), 64'd0);
        check_val("rst err_addr", 64'(err_addr), 64'd0);
        @(negedge clk);
        reset_ = 1'b1;
        @(negedge clk);

        run_txn(3'd3, 27'h0000010, 0, 3, 3);  // mapped, ready after 3 cycles
        run_txn(3'd6, 27'h0000010, 2, 0, 0);  // unmapped: addr 30'h3000_0010
        run_txn(3'd1, 27'h0000055, 2, 0, 0);  // timeout
        run_txn(3'd1, 27'h0000066, 0, 4, 1);  // ready on terminal cycle wins
        run_txn(3'd1, 27'h0000077, 0, 4, 2);  // wrong slave ready -> timeout
        run_txn(3'd4, 27'h0000123, 0, 1, 4);  // minimum-length access
        run_txn(3'd2, 27'h0000200, 1, 2, 0);  // abort after 2 cycles
        run_txn(3'd0, 27'h0000300, 0, 2, 0);  // back-to-back
        run_txn(3'd0, 27'h0000301, 3, 2, 0);  // abort + ready together
        run_txn(3'd7, 27'h7ffffff, 2, 0, 0);  // unmapped top index
        run_txn(3'd3, 27'h0000400, 1, 1, 0);  // abort on first cycle, no error

        for (int i = 0; i < 12; i++) begin
            run_txn(SIW'($urandom_range(0, 7)), (AW-SIW)'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
                    int'($urandom_range(0, NS - 1)));
        end

        // Force an error first so the reset visibly clears err_code/err_addr.
        run_txn(3'd5, 27'h0000abc, 2, 0, 0);
        in_addr = {3'd2, 27'h0000042};
        as_     = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        check_val("pre_reset cs_", 64'(cs_), 64'h1b);
        reset_ = 1'b0;
        #1;
        check_val("mid_reset cs_", 64'(cs_), 64'h1f);
        check_val("mid_reset busy", 64'(busy), 64'd0);
        check_val("mid_reset err_code", 64'(err_code), 64'd0);
        check_val("mid_reset err_addr", 64'(err_addr), 64'd0);
        as_ = 1'b1;
        last_code = 2'b00;
        last_addr = '0;
        @(negedge clk);
        @(negedge clk);
        reset_ = 1'b1;
        @(negedge clk);
        run_txn(3'd2, 27'h0000042, 0, 2, 2);  // clean access after reset

        repeat (3) @(negedge clk);
        check_val("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
